// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle between the VGA timing stage and the pattern generator.
// Latency: n/a (wires only). Backpressure: none; one pixel coordinate per clock.
// Ports: HPixel/VPixel/Vsync/mode_next toward the generator; R/G/B/mode/frame_cnt back.
interface vga_pattern_gen_if;
   logic [15:0] HPixel;
   logic [15:0] VPixel;
   logic        Vsync;
   logic        mode_next;
   logic [7:0]  R;
   logic [7:0]  G;
   logic [7:0]  B;
   logic [1:0]  mode;
   logic [15:0] frame_cnt;

   // master drives coordinates/sync/requests, slave (the generator) drives colour/status
   modport master (
      output HPixel, VPixel, Vsync, mode_next,
      input  R, G, B, mode, frame_cnt
   );
   modport slave (
      input  HPixel, VPixel, Vsync, mode_next,
      output R, G, B, mode, frame_cnt
   );
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: colour bars, checkerboard, gradient, bouncing box.
// Latency: 1 clk from HPixel/VPixel/mode to R/G/B. Backpressure: none, one pixel per clk.
// Ports: clk, rst (async active-high), bus = vga_pattern_gen_if.slave (pixel in, colour/mode/frame_cnt out).
module vga_pattern_gen #(
   parameter int H_ACTIVE         = 640,
   parameter int V_ACTIVE         = 480,
   parameter int BOX_SIZE         = 32,
   parameter int BOX_STEP         = 2,
   parameter int VSYNC_ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               rst,
   vga_pattern_gen_if.slave   bus
);

   localparam logic        VS_ACT = (VSYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
   localparam logic [15:0] BAR_W  = 16'(H_ACTIVE / 8);
   localparam logic [16:0] BX_MAX = 17'(H_ACTIVE - BOX_SIZE);
   localparam logic [16:0] BY_MAX = 17'(V_ACTIVE - BOX_SIZE);
   localparam logic [16:0] STEP   = 17'(BOX_STEP);
   localparam logic [16:0] SIZE   = 17'(BOX_SIZE);

   logic        vs_r;
   logic        frame_start;
   logic        pending;
   logic [1:0]  mode_q;
   logic [15:0] frame_cnt_q;
   logic [15:0] bx, by;
   logic        dx_neg, dy_neg;
   logic [15:0] bx_nxt, by_nxt;
   logic        dx_neg_nxt, dy_neg_nxt;
   logic [7:0]  r_d, g_d, b_d;
   logic [7:0]  r_q, g_q, b_q;

   // Frame start is the cycle in which the incoming Vsync is active while the
   // registered copy is still inactive; state commits on that cycle's edge.
   assign frame_start = (vs_r != VS_ACT) && (bus.Vsync == VS_ACT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_r        <= ~VS_ACT;
         pending     <= 1'b0;
         mode_q      <= 2'd0;
         frame_cnt_q <= 16'd0;
         bx          <= 16'd0;
         by          <= 16'd0;
         dx_neg      <= 1'b0;
         dy_neg      <= 1'b0;
      end else begin
         vs_r <= bus.Vsync;
         if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            // a request arriving in the frame-start cycle itself is folded in here
            if (pending || bus.mode_next) begin
               mode_q <= mode_q + 2'd1;
            end
            pending <= 1'b0;
            bx      <= bx_nxt;
            by      <= by_nxt;
            dx_neg  <= dx_neg_nxt;
            dy_neg  <= dy_neg_nxt;
         end else if (bus.mode_next) begin
            pending <= 1'b1;
         end
      end
   end

   // Box motion. Reaching a bound (exactly or by overshoot) clamps there and
   // flips direction, so the box leaves the edge on the very next frame.
   always_comb begin
      bx_nxt     = bx;
      by_nxt     = by;
      dx_neg_nxt = dx_neg;
      dy_neg_nxt = dy_neg;
      if (!dx_neg) begin
         if (({1'b0, bx} + STEP) >= BX_MAX) begin
            bx_nxt     = BX_MAX[15:0];
            dx_neg_nxt = 1'b1;
         end else begin
            bx_nxt = bx + STEP[15:0];
         end
      end else begin
         if ({1'b0, bx} <= STEP) begin
            bx_nxt     = 16'd0;
            dx_neg_nxt = 1'b0;
         end else begin
            bx_nxt = bx - STEP[15:0];
         end
      end
      if (!dy_neg) begin
         if (({1'b0, by} + STEP) >= BY_MAX) begin
            by_nxt     = BY_MAX[15:0];
            dy_neg_nxt = 1'b1;
         end else begin
            by_nxt = by + STEP[15:0];
         end
      end else begin
         if ({1'b0, by} <= STEP) begin
            by_nxt     = 16'd0;
            dy_neg_nxt = 1'b0;
         end else begin
            by_nxt = by - STEP[15:0];
         end
      end
   end

   // Pixel colour from the current coordinates and the mode register as it
   // stands in the same cycle.
   logic [15:0] bar;
   logic        in_active;
   logic        in_box;

   assign bar       = bus.HPixel / BAR_W;
   assign in_active = (bus.HPixel < 16'(H_ACTIVE)) && (bus.VPixel < 16'(V_ACTIVE));
   assign in_box    = ({1'b0, bus.HPixel} >= {1'b0, bx}) && ({1'b0, bus.HPixel} < ({1'b0, bx} + SIZE)) &&
                      ({1'b0, bus.VPixel} >= {1'b0, by}) && ({1'b0, bus.VPixel} < ({1'b0, by} + SIZE));

   always_comb begin
      r_d = 8'd0;
      g_d = 8'd0;
      b_d = 8'd0;
      if (in_active) begin
         unique case (mode_q)
            2'd0: begin
               case (bar)
                  16'd0:   {r_d, g_d, b_d} = 24'hFFFFFF;
                  16'd1:   {r_d, g_d, b_d} = 24'hFFFF00;
                  16'd2:   {r_d, g_d, b_d} = 24'h00FFFF;
                  16'd3:   {r_d, g_d, b_d} = 24'h00FF00;
                  16'd4:   {r_d, g_d, b_d} = 24'hFF00FF;
                  16'd5:   {r_d, g_d, b_d} = 24'hFF0000;
                  16'd6:   {r_d, g_d, b_d} = 24'h0000FF;
                  default: {r_d, g_d, b_d} = 24'h000000;
               endcase
            end
            2'd1: begin
               if (bus.HPixel[5] ^ bus.VPixel[5]) begin
                  {r_d, g_d, b_d} = 24'hFFFFFF;
               end
            end
            2'd2: begin
               r_d = bus.HPixel[7:0];
               g_d = bus.VPixel[7:0];
               b_d = frame_cnt_q[7:0];
            end
            default: begin
               {r_d, g_d, b_d} = in_box ? 24'hFFFFFF : 24'h0000FF;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= 8'd0;
         g_q <= 8'd0;
         b_q <= 8'd0;
      end else begin
         r_q <= r_d;
         g_q <= g_d;
         b_q <= b_d;
      end
   end

   assign bus.R         = r_q;
   assign bus.G         = g_q;
   assign bus.B         = b_q;
   assign bus.mode      = mode_q;
   assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen with a queue scoreboard of expected pixels.
module tb_vga_pattern_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   vga_pattern_gen_if vif ();

   vga_pattern_gen dut (.clk(clk), .rst(rst), .bus(vif));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [1:0]  mode_m;
   logic [15:0] fc_m;
   bit          pend_m;
   int          bx_m, by_m, dirx, diry;
   logic [23:0] exp_q[$];
   logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] exp_rgb(input int h, input int v);
      if (h >= 640 || v >= 480) return 24'h000000;
      case (mode_m)
         2'd0: return bar_tab[h / 80];
         2'd1: return ((((h / 32) + (v / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
         2'd2: return {h[7:0], v[7:0], fc_m[7:0]};
         default: return (h >= bx_m && h < bx_m + 32 && v >= by_m && v < by_m + 32)
                         ? 24'hFFFFFF : 24'h0000FF;
      endcase
   endfunction

   task automatic model_reset();
      mode_m = 2'd0; fc_m = 16'd0; pend_m = 1'b0;
      bx_m = 0; by_m = 0; dirx = 1; diry = 1;
   endtask

   task automatic px(input int h, input int v);
      logic [23:0] e;
      @(negedge clk);
      vif.HPixel = 16'(h);
      vif.VPixel = 16'(v);
      exp_q.push_back(exp_rgb(h, v));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("rgb m%0d h%0d v%0d", mode_m, h, v), {8'h0, vif.R, vif.G, vif.B}, {8'h0, e});
   endtask

   task automatic pulse_mode_next();
      @(negedge clk); vif.mode_next = 1'b1;
      @(negedge clk); vif.mode_next = 1'b0;
      pend_m = 1'b1;
   endtask

   // Vsync low for one clock; mn_fs is mode_next during the frame-start cycle,
   // mn_after is left on mode_next afterwards.
   task automatic frame_pulse(input bit mn_fs, input bit mn_after);
      int nb;
      @(negedge clk); vif.Vsync = 1'b0; vif.mode_next = mn_fs;
      @(negedge clk); vif.Vsync = 1'b1; vif.mode_next = mn_after;
      fc_m = fc_m + 16'd1;
      if (pend_m || mn_fs) mode_m = mode_m + 2'd1;
      pend_m = mn_after;
      nb = bx_m + 2 * dirx;
      if (nb >= 608) begin nb = 608; dirx = -1; end
      else if (nb <= 0) begin nb = 0; dirx = 1; end
      bx_m = nb;
      nb = by_m + 2 * diry;
      if (nb >= 448) begin nb = 448; diry = -1; end
      else if (nb <= 0) begin nb = 0; diry = 1; end
      by_m = nb;
   endtask

   task automatic check_state(input string tag);
      @(negedge clk);
      check({tag, " mode"}, {30'd0, vif.mode}, {30'd0, mode_m});
      check({tag, " frame_cnt"}, {16'd0, vif.frame_cnt}, {16'd0, fc_m});
   endtask

   task automatic out_of_range();
      px(700, 100);
      px(100, 500);
      px(640, 0);
      px(0, 480);
   endtask

   initial begin
      model_reset();
      vif.HPixel = 16'd0; vif.VPixel = 16'd0; vif.Vsync = 1'b1; vif.mode_next = 1'b0;
      repeat (3) @(negedge clk);
      check("reset rgb", {8'h0, vif.R, vif.G, vif.B}, 32'h0);
      check_state("reset");
      @(negedge clk); rst = 1'b0;

      // colour bars
      px(0, 10); px(80, 10); px(560, 10);
      for (int b = 0; b < 8; b++) px(b * 80 + 79, 200);
      out_of_range();

      // three requests collapse into one advance
      pulse_mode_next(); pulse_mode_next(); pulse_mode_next();
      check_state("pending hold");
      frame_pulse(1'b0, 1'b0);
      check_state("collapse");

      // checkerboard
      px(0, 0); px(32, 0); px(32, 32); px(100, 40); px(31, 63); px(639, 479);
      out_of_range();

      // mode_next held across four frame starts
      @(negedge clk); vif.mode_next = 1'b1; pend_m = 1'b1;
      for (int i = 0; i < 4; i++) begin
         frame_pulse(1'b1, (i < 3));
         check_state($sformatf("held %0d", i));
      end

      // gradient
      pulse_mode_next();
      frame_pulse(1'b0, 1'b0);
      check_state("to mode2");
      px(100, 50); px(639, 479); px(256, 300);
      out_of_range();
      while (fc_m != 16'd37) frame_pulse(1'b0, 1'b0);
      check_state("fc37");
      px(123, 45);

      // asynchronous reset mid-frame
      @(negedge clk); vif.HPixel = 16'd200; vif.VPixel = 16'd100;
      #2 rst = 1'b1;
      #1;
      check("async rst rgb", {8'h0, vif.R, vif.G, vif.B}, 32'h0);
      check("async rst mode", {30'd0, vif.mode}, 32'd0);
      check("async rst fc", {16'd0, vif.frame_cnt}, 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      check("rst hold rgb", {8'h0, vif.R, vif.G, vif.B}, 32'h0);
      rst = 1'b0;
      check_state("after rst");
      frame_pulse(1'b0, 1'b0);
      check_state("first frame");
      px(0, 10);

      // to the bouncing box
      for (int i = 0; i < 3; i++) begin
         pulse_mode_next();
         frame_pulse(1'b0, 1'b0);
      end
      check_state("to mode3");
      out_of_range();
      for (int f = 0; f < 400; f++) begin
         frame_pulse(1'b0, 1'b0);
         px(bx_m, by_m);
         px(bx_m + 31, by_m + 31);
         px(bx_m + 32, by_m + 5);
         px(bx_m + 5, by_m + 32);
         if (bx_m > 0) px(bx_m - 1, by_m + 5);
         if (by_m > 0) px(bx_m + 5, by_m - 1);
      end
      check_state("box end");

      check("scoreboard drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
